// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered read port, level flags and sticky error flags
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Chip_Select,
  input  logic                  Write_Enable,
  input  logic                  Read_Enable,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  Clear_Flags,
  output logic [DATA_WIDTH-1:0] Output,
  output logic                  Output_Valid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  assign Full = Count == (ADDR_WIDTH+1)'(DEPTH);
  assign Empty = Count == '0;
  assign Almost_Full = Count >= (ADDR_WIDTH+1)'(AF_LEVEL);
  assign Almost_Empty = Count <= (ADDR_WIDTH+1)'(AE_LEVEL);
  assign rd_acc = Chip_Select & Read_Enable & ~Empty;
  assign wr_acc = Chip_Select & Write_Enable & (~Full | rd_acc);
  always_ff @(posedge Clock)
    if (wr_acc) mem[wr_ptr] <= Data;
  // When full with both requests, rd_ptr == wr_ptr: the read sees the old word.
  always_ff @(posedge Clock)
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count <= '0;
      Output <= '0;
      Output_Valid <= 1'b0;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        Output <= mem[rd_ptr];
      end
      Output_Valid <= rd_acc;
      Count <= (wr_acc & ~rd_acc) ? Count + 1'b1 : (rd_acc & ~wr_acc) ? Count - 1'b1 : Count;
      Overflow <= (Overflow & ~Clear_Flags) | (Chip_Select & Write_Enable & Full & ~rd_acc);
      Underflow <= (Underflow & ~Clear_Flags) | (Chip_Select & Read_Enable & Empty);
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;
  logic Clock, Reset, Chip_Select, Write_Enable, Read_Enable, Clear_Flags;
  logic [7:0] Data, Output;
  logic Output_Valid, Full, Empty, Almost_Full, Almost_Empty, Overflow, Underflow;
  logic [5:0] Count;
  int tests = 0;
  int errs = 0;
  sync_fifo_param dut (
    .Clock(Clock), .Reset(Reset), .Chip_Select(Chip_Select), .Write_Enable(Write_Enable),
    .Read_Enable(Read_Enable), .Data(Data), .Clear_Flags(Clear_Flags), .Output(Output),
    .Output_Valid(Output_Valid), .Full(Full), .Empty(Empty), .Almost_Full(Almost_Full),
    .Almost_Empty(Almost_Empty), .Count(Count), .Overflow(Overflow), .Underflow(Underflow)
  );
  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic op(input logic cs, input logic we, input logic re, input logic [7:0] d,
                    input logic cf = 1'b0);
    Chip_Select = cs;
    Write_Enable = we;
    Read_Enable = re;
    Data = d;
    Clear_Flags = cf;
    @(posedge Clock);
    #1;
    Chip_Select = 0;
    Write_Enable = 0;
    Read_Enable = 0;
    Clear_Flags = 0;
  endtask
  task automatic chk_reset_state(input string tag);
    check({tag, "_count"}, Count, 0);
    check({tag, "_empty"}, Empty, 1);
    check({tag, "_full"}, Full, 0);
    check({tag, "_ae"}, Almost_Empty, 1);
    check({tag, "_af"}, Almost_Full, 0);
    check({tag, "_out"}, Output, 0);
    check({tag, "_valid"}, Output_Valid, 0);
    check({tag, "_ovf"}, Overflow, 0);
    check({tag, "_udf"}, Underflow, 0);
  endtask
  initial begin
    Reset = 1;
    Chip_Select = 0;
    Write_Enable = 0;
    Read_Enable = 0;
    Clear_Flags = 0;
    Data = 0;
    op(0, 0, 0, 0);
    op(0, 0, 0, 0);
    Reset = 0;
    chk_reset_state("rst");
    // 1: basic write/read ordering
    op(1, 1, 0, 8'h11);
    op(1, 1, 0, 8'h22);
    op(1, 1, 0, 8'h33);
    check("t1_count3", Count, 3);
    check("t1_valid_nowr", Output_Valid, 0);
    op(1, 0, 1, 0);
    check("t1_rd0", Output, 8'h11);
    check("t1_v0", Output_Valid, 1);
    op(1, 0, 1, 0);
    check("t1_rd1", Output, 8'h22);
    check("t1_v1", Output_Valid, 1);
    op(1, 0, 1, 0);
    check("t1_rd2", Output, 8'h33);
    check("t1_v2", Output_Valid, 1);
    check("t1_count0", Count, 0);
    check("t1_empty", Empty, 1);
    op(0, 0, 0, 0);
    check("t1_vpulse", Output_Valid, 0);
    check("t1_hold", Output, 8'h33);
    // 2: fill, flags, overflow, drain
    for (int i = 0; i < 32; i++) begin
      op(1, 1, 0, 8'(i));
      check("t2_count", Count, i + 1);
      check("t2_af", Almost_Full, (i + 1) >= 28);
      check("t2_ae", Almost_Empty, (i + 1) <= 4);
      check("t2_full", Full, (i + 1) == 32);
      check("t2_empty", Empty, 0);
    end
    op(1, 1, 0, 8'hAA);
    check("t2_ovf", Overflow, 1);
    check("t2_ovf_count", Count, 32);
    for (int i = 0; i < 32; i++) begin
      op(1, 0, 1, 0);
      check("t2_drain", Output, i);
    end
    check("t2_empty_end", Empty, 1);
    check("t2_ovf_sticky", Overflow, 1);
    // 3: underflow and clear
    op(1, 0, 1, 0);
    check("t3_udf", Underflow, 1);
    check("t3_valid", Output_Valid, 0);
    check("t3_out_hold", Output, 8'h1F);
    check("t3_count", Count, 0);
    op(1, 0, 0, 0, 1'b1);
    check("t3_udf_clr", Underflow, 0);
    check("t3_ovf_clr", Overflow, 0);
    // clear and new error on the same edge: set wins
    op(1, 0, 1, 0, 1'b1);
    check("t3_set_wins", Underflow, 1);
    op(1, 0, 0, 0, 1'b1);
    // 4: simultaneous read/write at full and at empty
    for (int i = 0; i < 32; i++) op(1, 1, 0, 8'(8'h40 + i));
    op(1, 1, 1, 8'h55);
    check("t4_full_count", Count, 32);
    check("t4_full_out", Output, 8'h40);
    check("t4_full_valid", Output_Valid, 1);
    check("t4_full_ovf", Overflow, 0);
    for (int i = 1; i < 32; i++) begin
      op(1, 0, 1, 0);
      check("t4_drain", Output, 8'h40 + i);
    end
    op(1, 0, 1, 0);
    check("t4_last", Output, 8'h55);
    check("t4_empty", Empty, 1);
    op(1, 1, 1, 8'h66);
    check("t4_e_count", Count, 1);
    check("t4_e_udf", Underflow, 1);
    check("t4_e_valid", Output_Valid, 0);
    check("t4_e_out", Output, 8'h55);
    op(1, 0, 1, 0);
    check("t4_e_rd", Output, 8'h66);
    op(1, 0, 0, 0, 1'b1);
    // 5: pointer wrap with interleaved pairs
    for (int i = 0; i < 100; i++) begin
      op(1, 1, 0, 8'(i + 3));
      check("t5_count_w", Count, 1);
      op(1, 0, 1, 0);
      check("t5_data", Output, 8'(i + 3));
      check("t5_count_r", Count, 0);
    end
    // 6: reset mid-burst, then chip select gating
    op(1, 0, 1, 0);
    check("t6_udf_pre", Underflow, 1);
    for (int i = 0; i < 10; i++) op(1, 1, 0, 8'(8'h80 + i));
    check("t6_count10", Count, 10);
    Reset = 1;
    op(1, 1, 1, 8'hEE);
    Reset = 0;
    chk_reset_state("t6_rst");
    op(1, 1, 0, 8'h99);
    op(1, 0, 1, 0);
    check("t6_post", Output, 8'h99);
    check("t6_post_count", Count, 0);
    op(0, 1, 1, 8'h77);
    check("t6_cs_count", Count, 0);
    check("t6_cs_udf", Underflow, 0);
    check("t6_cs_valid", Output_Valid, 0);
    op(1, 1, 0, 8'h12);
    op(0, 1, 1, 8'h34);
    check("t6_cs2_count", Count, 1);
    check("t6_cs2_out", Output, 8'h99);
    check("t6_cs2_valid", Output_Valid, 0);
    op(1, 0, 1, 0);
    check("t6_cs2_rd", Output, 8'h12);
    check("t6_cs2_empty", Empty, 1);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
